cc_miss_dispatch_unit: RTL and testbench

Cache-controller stage directly upstream of the data reorder unit. Accepts one tag-lookup result per handshake, pushes its hit/miss flag into the hit flag FIFO in program order, pushes hit lines into the hit data FIFO, and issues one 8-beat wrapping AXI AR burst to memory per miss. Backpressure comes from FIFO almost-full flags and a limit on outstanding misses.

---
 rtl/cc_miss_dispatch_unit.sv | 150 +++++++++++++++
 tb/tb_cc_miss_dispatch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_miss_dispatch_unit.sv
// cc_miss_dispatch_unit: accepts tag-lookup results and pushes hit/miss flags
// and hit lines into the downstream FIFOs. It issues one 8-beat wrapping AR
// burst per miss and bounds the number of in-flight misses.
// Optional feature macro: CC_MISS_DISPATCH_PERF_EN (hit/miss perf counters).
module cc_miss_dispatch_unit #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lookup_valid_i,
  output logic         lookup_ready_o,
  input  logic         lookup_hit_i,
  input  logic [31:0]  lookup_addr_i,
  input  logic [511:0] lookup_data_i,
  input  logic         hit_flag_fifo_afull_i,
  output logic         hit_flag_fifo_wren_o,
  output logic         hit_flag_fifo_wdata_o,
  input  logic         hit_data_fifo_afull_i,
  output logic         hit_data_fifo_wren_o,
  output logic [517:0] hit_data_fifo_wdata_o,
  output logic [31:0]  mem_araddr_o,
  output logic [3:0]   mem_arlen_o,
  output logic [2:0]   mem_arsize_o,
  output logic [1:0]   mem_arburst_o,
  output logic         mem_arvalid_o,
  input  logic         mem_arready_i,
  input  logic         mem_rvalid_i,
  input  logic         mem_rready_i,
  input  logic         mem_rlast_i,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_AR = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   outstanding_q, outstanding_d;
  logic               flag_wren_q, flag_wren_d;
  logic               flag_wdata_q, flag_wdata_d;
  logic               data_wren_q, data_wren_d;
  logic [517:0]       data_wdata_q, data_wdata_d;
  logic [31:0]        araddr_q, araddr_d;

  logic accept, hit_acc, miss_acc, retire;

  // Ready depends on the hit flag but never on valid, so it is safe to present.
  always_comb begin
    lookup_ready_o = 1'b0;
    if (state_q == ST_IDLE && !hit_flag_fifo_afull_i) begin
      if (lookup_hit_i) lookup_ready_o = !hit_data_fifo_afull_i;
      else              lookup_ready_o = (outstanding_q < OUT_W'(MAX_OUTSTANDING));
    end
  end

  assign accept   = lookup_valid_i && lookup_ready_o;
  assign hit_acc  = accept && lookup_hit_i;
  assign miss_acc = accept && !lookup_hit_i;
  // A retire seen with nothing outstanding is ignored so the counter never wraps.
  assign retire   = mem_rvalid_i && mem_rready_i && mem_rlast_i && (outstanding_q != '0);

  // Next-state logic: a miss parks the FSM in AR until the request is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (miss_acc) state_d = ST_AR;
      ST_AR:   if (mem_arready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Push strobes, push payloads, AR address and outstanding-miss count.
  always_comb begin
    flag_wren_d   = accept;
    flag_wdata_d  = hit_acc;
    data_wren_d   = hit_acc;
    data_wdata_d  = data_wdata_q;
    araddr_d      = araddr_q;
    outstanding_d = outstanding_q;
    if (hit_acc)  data_wdata_d = {lookup_addr_i[5:0], lookup_data_i};
    if (miss_acc) araddr_d = {lookup_addr_i[31:3], 3'b000};
    case ({miss_acc, retire})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State registers; reset drops any pending AR and clears all bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      outstanding_q <= '0;
      flag_wren_q   <= 1'b0;
      flag_wdata_q  <= 1'b0;
      data_wren_q   <= 1'b0;
      data_wdata_q  <= '0;
      araddr_q      <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      flag_wren_q   <= flag_wren_d;
      flag_wdata_q  <= flag_wdata_d;
      data_wren_q   <= data_wren_d;
      data_wdata_q  <= data_wdata_d;
      araddr_q      <= araddr_d;
    end
  end

  assign hit_flag_fifo_wren_o  = flag_wren_q;
  assign hit_flag_fifo_wdata_o = flag_wdata_q;
  assign hit_data_fifo_wren_o  = data_wren_q;
  assign hit_data_fifo_wdata_o = data_wdata_q;
  assign mem_araddr_o          = araddr_q;
  assign mem_arvalid_o         = (state_q == ST_AR);
  assign mem_arlen_o           = 4'd7;
  assign mem_arsize_o          = 3'd3;
  assign mem_arburst_o         = 2'b10;

`ifdef CC_MISS_DISPATCH_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Saturating event counters for accepted hits and misses.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_acc  && hit_cnt_q  != 32'hFFFF_FFFF) hit_cnt_d  = hit_cnt_q  + 32'd1;
    if (miss_acc && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cc_miss_dispatch_unit.sv
// Bench for cc_miss_dispatch_unit: two instances (MAX_OUTSTANDING 4 and 2)
// share one stimulus stream and are compared every cycle against a
// transaction-level model, with directed literal expectations on top.
module tb_cc_miss_dispatch_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0, hit = 1'b0;
  logic [31:0]  addr = '0;
  logic [511:0] data = '0;
  logic         flag_afull = 1'b0, data_afull = 1'b0;
  logic         arready = 1'b0, rvalid = 1'b0, rready = 1'b0, rlast = 1'b0;

  logic         rdy[2], fw[2], fd[2], dw[2], av[2];
  logic [517:0] dd[2];
  logic [31:0]  aa[2], hc[2], mc[2];
  logic [3:0]   alen[2];
  logic [2:0]   asz[2];
  logic [1:0]   abur[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cc_miss_dispatch_unit #(.MAX_OUTSTANDING(4)) u_dut0 (
    .clk(clk), .rst(rst), .lookup_valid_i(valid), .lookup_ready_o(rdy[0]),
    .lookup_hit_i(hit), .lookup_addr_i(addr), .lookup_data_i(data),
    .hit_flag_fifo_afull_i(flag_afull), .hit_flag_fifo_wren_o(fw[0]),
    .hit_flag_fifo_wdata_o(fd[0]), .hit_data_fifo_afull_i(data_afull),
    .hit_data_fifo_wren_o(dw[0]), .hit_data_fifo_wdata_o(dd[0]),
    .mem_araddr_o(aa[0]), .mem_arlen_o(alen[0]), .mem_arsize_o(asz[0]),
    .mem_arburst_o(abur[0]), .mem_arvalid_o(av[0]), .mem_arready_i(arready),
    .mem_rvalid_i(rvalid), .mem_rready_i(rready), .mem_rlast_i(rlast),
    .hit_cnt_o(hc[0]), .miss_cnt_o(mc[0]));

  cc_miss_dispatch_unit #(.MAX_OUTSTANDING(2)) u_dut1 (
    .clk(clk), .rst(rst), .lookup_valid_i(valid), .lookup_ready_o(rdy[1]),
    .lookup_hit_i(hit), .lookup_addr_i(addr), .lookup_data_i(data),
    .hit_flag_fifo_afull_i(flag_afull), .hit_flag_fifo_wren_o(fw[1]),
    .hit_flag_fifo_wdata_o(fd[1]), .hit_data_fifo_afull_i(data_afull),
    .hit_data_fifo_wren_o(dw[1]), .hit_data_fifo_wdata_o(dd[1]),
    .mem_araddr_o(aa[1]), .mem_arlen_o(alen[1]), .mem_arsize_o(asz[1]),
    .mem_arburst_o(abur[1]), .mem_arvalid_o(av[1]), .mem_arready_i(arready),
    .mem_rvalid_i(rvalid), .mem_rready_i(rready), .mem_rlast_i(rlast),
    .hit_cnt_o(hc[1]), .miss_cnt_o(mc[1]));

  task automatic check(input string name, input logic [517:0] act, input logic [517:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_out[2]  = '{0, 0};   // misses in flight
  bit           m_ar[2]   = '{0, 0};   // AR request waiting for arready
  logic [31:0]  m_araddr[2];
  bit           e_fw[2]   = '{0, 0};
  bit           e_fd[2]   = '{0, 0};
  bit           e_dw[2]   = '{0, 0};
  logic [517:0] e_dd[2];
  logic [31:0]  m_hits[2] = '{0, 0};
  logic [31:0]  m_miss[2] = '{0, 0};

  function automatic int max_out(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic bit m_ready(input int k);
    if (m_ar[k] || flag_afull) return 1'b0;
    if (hit) return !data_afull;
    return m_out[k] < max_out(k);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_out[k] <= 0; m_ar[k] <= 1'b0; e_fw[k] <= 1'b0; e_fd[k] <= 1'b0;
        e_dw[k] <= 1'b0; m_hits[k] <= '0; m_miss[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic bit acc = valid && m_ready(k);
        automatic int inc = (acc && !hit) ? 1 : 0;
        automatic int dec = (rvalid && rready && rlast && m_out[k] > 0) ? 1 : 0;
        e_fw[k] <= acc;
        e_fd[k] <= acc && hit;
        e_dw[k] <= acc && hit;
        if (acc && hit) begin
          e_dd[k] <= {addr[5:0], data};
          if (m_hits[k] != 32'hFFFF_FFFF) m_hits[k] <= m_hits[k] + 1;
        end
        if (acc && !hit) begin
          m_ar[k]     <= 1'b1;
          m_araddr[k] <= {addr[31:3], 3'b000};
          if (m_miss[k] != 32'hFFFF_FFFF) m_miss[k] <= m_miss[k] + 1;
        end else if (m_ar[k] && arready) begin
          m_ar[k] <= 1'b0;
        end
        m_out[k] <= m_out[k] + inc - dec;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("ready%0d", k), rdy[k], m_ready(k));
        check($sformatf("flag_wren%0d", k), fw[k], e_fw[k]);
        if (e_fw[k]) check($sformatf("flag_wdata%0d", k), fd[k], e_fd[k]);
        check($sformatf("data_wren%0d", k), dw[k], e_dw[k]);
        if (e_dw[k]) check($sformatf("data_wdata%0d", k), dd[k], e_dd[k]);
        check($sformatf("arvalid%0d", k), av[k], m_ar[k]);
        if (m_ar[k]) check($sformatf("araddr%0d", k), aa[k], m_araddr[k]);
        check($sformatf("arconst%0d", k), {alen[k], asz[k], abur[k]}, {4'd7, 3'd3, 2'b10});
`ifdef CC_MISS_DISPATCH_PERF_EN
        check($sformatf("hit_cnt%0d", k), hc[k], m_hits[k]);
        check($sformatf("miss_cnt%0d", k), mc[k], m_miss[k]);
`else
        check($sformatf("hit_cnt%0d", k), hc[k], 32'd0);
        check($sformatf("miss_cnt%0d", k), mc[k], 32'd0);
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lookup(input logic v, input logic h, input logic [31:0] a);
    valid = v;
    hit   = h;
    addr  = a;
    data  = {16{a}};
  endtask

  task automatic set_retire(input logic r);
    rvalid = r;
    rready = r;
    rlast  = r;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_flag_wren", fw[0], 1'b0);
    check("rst_arvalid", av[0], 1'b0);
    check("rst_araddr", aa[0], 32'd0);
    check("rst_hit_cnt", hc[0], 32'd0);
    rst = 1'b0;

    // three back-to-back hits
    set_lookup(1, 1, 32'h40);
    #1 check("t1_ready", rdy[0], 1'b1);
    tick;
    check("t1_flag0", {fw[0], fd[0], dw[0]}, 3'b111);
    check("t1_off0", dd[0][517:512], 6'h00);
    set_lookup(1, 1, 32'h88);
    tick;
    check("t1_flag1", {fw[0], fd[0], dw[0]}, 3'b111);
    check("t1_off1", dd[0][517:512], 6'h08);
    set_lookup(1, 1, 32'hC5);
    tick;
    check("t1_flag2", {fw[0], fd[0], dw[0]}, 3'b111);
    check("t1_off2", dd[0][517:512], 6'h05);
    check("t1_noar", av[0], 1'b0);
    set_lookup(0, 0, 32'h0);
    tick;
    check("t1_idle", fw[0], 1'b0);

    // miss with arready held low for three cycles
    arready = 1'b0;
    set_lookup(1, 0, 32'h1234_567D);
    #1 check("t2_ready", rdy[0], 1'b1);
    tick;
    set_lookup(0, 0, 32'h0);
    check("t2_flag", {fw[0], fd[0]}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      check("t2_arvalid", av[0], 1'b1);
      check("t2_araddr", aa[0], 32'h1234_5678);
      check("t2_arlen", alen[0], 4'd7);
      check("t2_arburst", abur[0], 2'b10);
      #1 check("t2_ready_low", rdy[0], 1'b0);
      if (i > 0) check("t2_single_push", fw[0], 1'b0);
      if (i == 3) arready = 1'b1;
      tick;
    end
    check("t2_ar_done", av[0], 1'b0);

    // outstanding limit (instance 1 has MAX 2); both now hold one miss
    set_lookup(1, 0, 32'h1000);
    tick;
    set_lookup(0, 0, 32'h0);
    tick;
    set_lookup(1, 0, 32'h2000);
    #1 check("t3_stall", rdy[1], 1'b0);
    check("t3_max4_ready", rdy[0], 1'b1);
    tick;
    set_lookup(0, 0, 32'h0);
    tick;
    set_retire(1);
    #1 check("t3_still_stall", rdy[1], 1'b0);
    tick;
    // instance 0 now at 2 outstanding: accept and retire together
    set_lookup(1, 0, 32'h2000);
    #1 check("t3_resume", rdy[1], 1'b1);
    tick;
    check("t3_accepted", {fw[1], fd[1], fw[0]}, 3'b101);
    set_retire(0);
    set_lookup(0, 0, 32'h0);
    tick;
    set_lookup(1, 0, 32'h3000);
    tick;
    set_lookup(0, 0, 32'h0);
    tick;
    set_lookup(1, 0, 32'h3040);
    #1 check("t4_third_ok", rdy[0], 1'b1);
    tick;
    set_lookup(0, 0, 32'h0);
    tick;
    set_lookup(1, 0, 32'h3080);
    #1 check("t4_full", rdy[0], 1'b0);
    set_lookup(0, 0, 32'h0);
    set_retire(1);
    repeat (6) tick;
    set_retire(0);
    tick;

    // data FIFO almost full blocks a hit but not a miss
    data_afull = 1'b1;
    set_lookup(1, 1, 32'h55);
    #1 check("t5_hit_blocked", {rdy[0], rdy[1]}, 2'b00);
    tick;
    check("t5_no_push", fw[0], 1'b0);
    set_lookup(1, 0, 32'h55);
    #1 check("t5_miss_ready", rdy[0], 1'b1);
    tick;
    check("t5_miss_push", {fw[0], fd[0]}, 2'b10);
    set_lookup(0, 0, 32'h0);
    data_afull = 1'b0;
    tick;
    flag_afull = 1'b1;
    set_lookup(1, 1, 32'h66);
    #1 check("t5_flag_afull", rdy[0], 1'b0);
    flag_afull = 1'b0;
    set_lookup(0, 0, 32'h0);
    tick;

    // reset while an AR is pending
    arready = 1'b0;
    set_lookup(1, 0, 32'h7777_0000);
    tick;
    set_lookup(0, 0, 32'h0);
    check("t6_ar_pending", av[0], 1'b1);
    #2 rst = 1'b1;
    #1 check("t6_arvalid_cleared", {av[0], av[1]}, 2'b00);
    check("t6_flag_cleared", fw[0], 1'b0);
    check("t6_hit_cnt_cleared", hc[0], 32'd0);
    check("t6_miss_cnt_cleared", mc[0], 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    arready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_lookup(1, 1, 32'h100 + 32'(i) * 32'h40);
      tick;
    end
    set_lookup(0, 0, 32'h0);
    tick;
`ifdef CC_MISS_DISPATCH_PERF_EN
    check("t6_hit_cnt", hc[0], 32'd5);
`else
    check("t6_hit_cnt", hc[0], 32'd0);
`endif
    check("t6_miss_cnt", mc[0], 32'd0);
    repeat (2) tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
